// File: rtl/dm_waitstate.sv
// dm_waitstate: parametrised data memory with a Read/Write/Ready handshake.
// Features: configurable depth, LATENCY wait states, latched requests, and a
// sequential clear sweep after reset. The sweep lets the array map onto block RAM.
// Optional feature macro: DM_BOUNDS_CHECK_EN. When it is defined, addresses above
// the decoded range are flagged on DataMem_Error. Their writes are dropped and
// their reads return 32'hDEAD_BEEF.
module dm_waitstate #(
  parameter int ADDR_BITS      = 9,
  parameter int LATENCY        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DataMem_Read,
  input  logic [3:0]  DataMem_Write,
  input  logic [29:0] DataMem_Address,
  input  logic [31:0] DataMem_In,
  output logic [31:0] DataMem_Out,
  output logic        DataMem_Ready,
  output logic        DataMem_Busy,
  output logic        DataMem_Error
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_BITS-1:0] lat_idx_q, lat_idx_d;
  logic                 lat_oob_q, lat_oob_d;
  logic [3:0]           lat_be_q, lat_be_d;
  logic [31:0]          lat_wdata_q, lat_wdata_d;
  logic                 lat_wr_q, lat_wr_d;
  logic [31:0]          out_q, out_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;

  logic                 req_rd, req_wr, req_valid, in_oob;
  logic                 acc_go, acc_oob, acc_wr;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [3:0]           acc_be;
  logic [31:0]          acc_wdata;
  logic                 mem_we;
  logic [3:0]           mem_be;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [31:0]          mem_wdata;

  // A request is only valid when exactly one direction is asserted.
  assign req_rd    = DataMem_Read && (DataMem_Write == 4'b0000);
  assign req_wr    = !DataMem_Read && (DataMem_Write != 4'b0000);
  assign req_valid = req_rd || req_wr;

`ifdef DM_BOUNDS_CHECK_EN
  assign in_oob = (DataMem_Address >> ADDR_BITS) != 30'd0;
`else
  logic unused_addr_hi;
  assign in_oob         = 1'b0;
  assign unused_addr_hi = |(DataMem_Address >> ADDR_BITS);
`endif

  assign DataMem_Out   = out_q;
  assign DataMem_Ready = ready_q;
  assign DataMem_Error = error_q;
  assign DataMem_Busy  = (state_q != ST_IDLE) || req_valid;

  // Next-state logic: sweep, request capture, wait countdown and the access itself.
  // The access is performed on the edge that enters ST_ACCESS. This makes the data
  // valid in the same cycle Ready is high.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    clr_addr_d  = clr_addr_q;
    lat_idx_d   = lat_idx_q;
    lat_oob_d   = lat_oob_q;
    lat_be_d    = lat_be_q;
    lat_wdata_d = lat_wdata_q;
    lat_wr_d    = lat_wr_q;
    out_d       = out_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    acc_go      = 1'b0;
    acc_idx     = lat_idx_q;
    acc_oob     = lat_oob_q;
    acc_be      = lat_be_q;
    acc_wdata   = lat_wdata_q;
    acc_wr      = lat_wr_q;
    mem_we      = 1'b0;
    mem_be      = 4'b0000;
    mem_idx     = clr_addr_q;
    mem_wdata   = 32'd0;

    case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_be     = 4'b1111;
        mem_idx    = clr_addr_q;
        mem_wdata  = 32'd0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_BITS{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          lat_idx_d   = DataMem_Address[ADDR_BITS-1:0];
          lat_oob_d   = in_oob;
          lat_be_d    = DataMem_Write;
          lat_wdata_d = DataMem_In;
          lat_wr_d    = req_wr;
          acc_idx     = DataMem_Address[ADDR_BITS-1:0];
          acc_oob     = in_oob;
          acc_be      = DataMem_Write;
          acc_wdata   = DataMem_In;
          acc_wr      = req_wr;
          if (LATENCY == 0) begin
            acc_go  = 1'b1;
            state_d = ST_ACCESS;
          end else begin
            wcnt_d  = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          acc_go  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (acc_go) begin
      ready_d = 1'b1;
      mem_idx = acc_idx;
      if (acc_oob) begin
        error_d = 1'b1;
        out_d   = acc_wr ? acc_wdata : 32'hDEAD_BEEF;
      end else if (acc_wr) begin
        mem_we    = 1'b1;
        mem_be    = acc_be;
        mem_wdata = acc_wdata;
        out_d     = acc_wdata;
      end else begin
        out_d = mem[acc_idx];
      end
    end
  end

  // State register with synchronous reset; reset drops any request in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      wcnt_q      <= 4'd0;
      clr_addr_q  <= '0;
      lat_idx_q   <= '0;
      lat_oob_q   <= 1'b0;
      lat_be_q    <= 4'b0000;
      lat_wdata_q <= 32'd0;
      lat_wr_q    <= 1'b0;
      out_q       <= 32'd0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      clr_addr_q  <= clr_addr_d;
      lat_idx_q   <= lat_idx_d;
      lat_oob_q   <= lat_oob_d;
      lat_be_q    <= lat_be_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wr_q    <= lat_wr_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Byte-lane write port of the storage array; suppressed while reset is asserted.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_waitstate.sv
// tb_dm_waitstate: self-checking bench for dm_waitstate.
// A transaction-level memory model supplies every expected value.
// Bound-check expectations follow the DM_BOUNDS_CHECK_EN macro.
module tb_dm_waitstate;

  localparam int ADDR_BITS = 4;
  localparam int LATENCY   = 3;
  localparam int DEPTH     = 1 << ADDR_BITS;
`ifdef DM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        DataMem_Read = 1'b0;
  logic [3:0]  DataMem_Write = 4'b0000;
  logic [29:0] DataMem_Address = 30'd0;
  logic [31:0] DataMem_In = 32'd0;
  logic [31:0] DataMem_Out;
  logic        DataMem_Ready;
  logic        DataMem_Busy;
  logic        DataMem_Error;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];

  dm_waitstate #(
    .ADDR_BITS(ADDR_BITS),
    .LATENCY(LATENCY),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .DataMem_Read(DataMem_Read),
    .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address),
    .DataMem_In(DataMem_In),
    .DataMem_Out(DataMem_Out),
    .DataMem_Ready(DataMem_Ready),
    .DataMem_Busy(DataMem_Busy),
    .DataMem_Error(DataMem_Error)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endfunction

  function automatic void model_txn(input logic wr, input logic [3:0] be, input logic [29:0] addr,
                                    input logic [31:0] wdata, output logic [31:0] exp_out,
                                    output logic exp_err);
    int idx;
    bit oob;
    idx     = int'(addr) % DEPTH;
    oob     = BOUNDS && (int'(addr) >= DEPTH);
    exp_err = oob;
    if (wr) begin
      exp_out = wdata;
      if (!oob)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      exp_out = oob ? 32'hDEADBEEF : model_mem[idx];
    end
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (DataMem_Ready !== 1'b1 && cycles < 60);
  endtask

  task automatic drive_txn(input logic rd, input logic [3:0] we, input logic [29:0] addr,
                           input logic [31:0] wdata, output int cycles, output logic [31:0] out,
                           output logic err, output logic busy0);
    DataMem_Read    = rd;
    DataMem_Write   = we;
    DataMem_Address = addr;
    DataMem_In      = wdata;
    #1 busy0 = DataMem_Busy;
    wait_ready(cycles);
    out = DataMem_Out;
    err = DataMem_Error;
    DataMem_Read  = 1'b0;
    DataMem_Write = 4'b0000;
    @(posedge clock); #1;
  endtask

  task automatic measure_sweep(output int n);
    n = 0;
    while (DataMem_Busy === 1'b1 && n < 4*DEPTH + 10) begin
      n++;
      @(posedge clock); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (DataMem_Ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b want=0", DataMem_Ready); end
    checks++; if (DataMem_Out !== 32'd0) begin errors++; $display("[TB] FAIL reset_out got=%h want=0", DataMem_Out); end
    checks++; if (DataMem_Error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%b want=0", DataMem_Error); end
    checks++; if (DataMem_Busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got=%b want=1", DataMem_Busy); end
    reset = 1'b0;
    measure_sweep(n);
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL reset_sweep_len got=%0d want=%0d", n, DEPTH); end
    model_clear();
  endtask

  task automatic test_sweep();
    int cyc, n; logic [31:0] out, eo; logic err, ee, b0;
    drive_txn(1'b0, 4'hF, 30'd5, 32'h12345678, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'd5, 32'h12345678, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL sweep_preload got=%h want=%h", out, eo); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (DataMem_Out !== 32'd0) begin errors++; $display("[TB] FAIL sweep_out_cleared got=%h want=0", DataMem_Out); end
    measure_sweep(n);
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL sweep_busy_len got=%0d want=%0d", n, DEPTH); end
    model_clear();
    drive_txn(1'b1, 4'h0, 30'd5, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd5, 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL sweep_word5 got=%h want=%h", out, eo); end
  endtask

  task automatic test_latency();
    int cyc; logic [31:0] out, eo; logic err, ee, b0;
    drive_txn(1'b0, 4'hF, 30'd7, 32'hCAFEF00D, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'd7, 32'hCAFEF00D, eo, ee);
    checks++; if (cyc != LATENCY + 1) begin errors++; $display("[TB] FAIL lat_write_cycles got=%0d want=%0d", cyc, LATENCY + 1); end
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL lat_write_echo got=%h want=%h", out, eo); end
    drive_txn(1'b1, 4'h0, 30'd7, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd7, 32'd0, eo, ee);
    checks++; if (cyc != LATENCY + 1) begin errors++; $display("[TB] FAIL lat_read_cycles got=%0d want=%0d", cyc, LATENCY + 1); end
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL lat_read_data got=%h want=%h", out, eo); end
    checks++; if (DataMem_Out !== eo) begin errors++; $display("[TB] FAIL lat_out_hold got=%h want=%h", DataMem_Out, eo); end
  endtask

  task automatic test_byte_merge();
    int cyc; logic [31:0] out, eo; logic err, ee, b0;
    drive_txn(1'b0, 4'hF, 30'd2, 32'h11223344, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'd2, 32'h11223344, eo, ee);
    drive_txn(1'b0, 4'b0101, 30'd2, 32'hAABBCCDD, cyc, out, err, b0);
    model_txn(1'b1, 4'b0101, 30'd2, 32'hAABBCCDD, eo, ee);
    drive_txn(1'b1, 4'h0, 30'd2, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd2, 32'd0, eo, ee);
    checks++; if (out !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL byte_merge got=%h want=%h", out, 32'h11BB33DD); end
  endtask

  task automatic test_illegal();
    int cyc; logic [31:0] out, eo; logic err, ee, b0;
    DataMem_Read    = 1'b1;
    DataMem_Write   = 4'b0001;
    DataMem_Address = 30'd2;
    DataMem_In      = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++; if (DataMem_Ready !== 1'b0) begin errors++; $display("[TB] FAIL illegal_ready cyc=%0d got=%b want=0", i, DataMem_Ready); end
      checks++; if (DataMem_Busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy cyc=%0d got=%b want=0", i, DataMem_Busy); end
    end
    DataMem_Read  = 1'b0;
    DataMem_Write = 4'b0000;
    @(posedge clock); #1;
    drive_txn(1'b1, 4'h0, 30'd2, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd2, 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL illegal_mem_unchanged got=%h want=%h", out, eo); end
  endtask

  task automatic test_latched_inputs();
    int cyc; logic [31:0] out, eo, eo10; logic err, ee, b0;
    model_txn(1'b1, 4'hF, 30'd9, 32'h600DF00D, eo, ee);
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'hF;
    DataMem_Address = 30'd9;
    DataMem_In      = 32'h600DF00D;
    @(posedge clock); #1;
    checks++; if (DataMem_Ready !== 1'b0) begin errors++; $display("[TB] FAIL latch_early_ready got=%b want=0", DataMem_Ready); end
    DataMem_Address = 30'd10;
    DataMem_In      = 32'hBAD0BAD0;
    DataMem_Write   = 4'b0001;
    wait_ready(cyc);
    checks++; if (cyc + 1 != LATENCY + 1) begin errors++; $display("[TB] FAIL latch_cycles got=%0d want=%0d", cyc + 1, LATENCY + 1); end
    checks++; if (DataMem_Out !== eo) begin errors++; $display("[TB] FAIL latch_echo got=%h want=%h", DataMem_Out, eo); end
    DataMem_Write = 4'b0000;
    @(posedge clock); #1;
    drive_txn(1'b1, 4'h0, 30'd9, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd9, 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL latch_word9 got=%h want=%h", out, eo); end
    drive_txn(1'b1, 4'h0, 30'd10, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd10, 32'd0, eo10, ee);
    checks++; if (out !== eo10) begin errors++; $display("[TB] FAIL latch_word10 got=%h want=%h", out, eo10); end
  endtask

  task automatic test_reset_mid_txn();
    int cyc, n; logic [31:0] out, eo; logic err, ee, b0;
    drive_txn(1'b0, 4'hF, 30'd3, 32'h5A5A5A5A, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'd3, 32'h5A5A5A5A, eo, ee);
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'hF;
    DataMem_Address = 30'd3;
    DataMem_In      = 32'h0F0F0F0F;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    DataMem_Write = 4'b0000;
    checks++; if (DataMem_Ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready got=%b want=0", DataMem_Ready); end
    checks++; if (DataMem_Out !== 32'd0) begin errors++; $display("[TB] FAIL midrst_out got=%h want=0", DataMem_Out); end
    measure_sweep(n);
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL midrst_sweep_len got=%0d want=%0d", n, DEPTH); end
    model_clear();
    drive_txn(1'b1, 4'h0, 30'd3, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd3, 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL midrst_word3 got=%h want=%h", out, eo); end
  endtask

  task automatic test_bounds();
    int cyc; logic [31:0] out, eo; logic err, ee, b0;
    drive_txn(1'b0, 4'hF, 30'd0, 32'h01020304, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'd0, 32'h01020304, eo, ee);
    drive_txn(1'b0, 4'hF, 30'(DEPTH), 32'hFFEEDDCC, cyc, out, err, b0);
    model_txn(1'b1, 4'hF, 30'(DEPTH), 32'hFFEEDDCC, eo, ee);
    checks++; if (cyc != LATENCY + 1) begin errors++; $display("[TB] FAIL bounds_wr_cycles got=%0d want=%0d", cyc, LATENCY + 1); end
    checks++; if (err !== ee) begin errors++; $display("[TB] FAIL bounds_wr_error got=%b want=%b", err, ee); end
    checks++; if (DataMem_Error !== 1'b0) begin errors++; $display("[TB] FAIL bounds_error_pulse got=%b want=0", DataMem_Error); end
    drive_txn(1'b1, 4'h0, 30'(DEPTH), 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'(DEPTH), 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL bounds_rd_data got=%h want=%h", out, eo); end
    checks++; if (err !== ee) begin errors++; $display("[TB] FAIL bounds_rd_error got=%b want=%b", err, ee); end
    drive_txn(1'b1, 4'h0, 30'd0, 32'd0, cyc, out, err, b0);
    model_txn(1'b0, 4'h0, 30'd0, 32'd0, eo, ee);
    checks++; if (out !== eo) begin errors++; $display("[TB] FAIL bounds_word0 got=%h want=%h", out, eo); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL bounds_word0_error got=%b want=0", err); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic [31:0] eo; logic ee;
    model_txn(1'b0, 4'h0, 30'd7, 32'd0, eo, ee);
    DataMem_Read    = 1'b1;
    DataMem_Write   = 4'b0000;
    DataMem_Address = 30'd7;
    wait_ready(c1);
    checks++; if (c1 != LATENCY + 1) begin errors++; $display("[TB] FAIL b2b_first_cycles got=%0d want=%0d", c1, LATENCY + 1); end
    wait_ready(c2);
    checks++; if (c2 != LATENCY + 2) begin errors++; $display("[TB] FAIL b2b_second_cycles got=%0d want=%0d", c2, LATENCY + 2); end
    checks++; if (DataMem_Out !== eo) begin errors++; $display("[TB] FAIL b2b_data got=%h want=%h", DataMem_Out, eo); end
    DataMem_Read = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int cyc; logic [31:0] out, eo, wd; logic err, ee, b0, rd; logic [3:0] we; logic [29:0] addr;
    for (int t = 0; t < 40; t++) begin
      rd   = 1'($urandom_range(0, 1));
      we   = rd ? 4'h0 : 4'($urandom_range(1, 15));
      wd   = $urandom;
      addr = 30'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) addr = addr + 30'(DEPTH * $urandom_range(1, 5));
      drive_txn(rd, we, addr, wd, cyc, out, err, b0);
      model_txn(!rd, we, addr, wd, eo, ee);
      checks++; if (b0 !== 1'b1) begin errors++; $display("[TB] FAIL rand_busy t=%0d got=%b want=1", t, b0); end
      checks++; if (cyc != LATENCY + 1) begin errors++; $display("[TB] FAIL rand_cycles t=%0d got=%0d want=%0d", t, cyc, LATENCY + 1); end
      checks++; if (out !== eo) begin errors++; $display("[TB] FAIL rand_data t=%0d addr=%h got=%h want=%h", t, addr, out, eo); end
      checks++; if (err !== ee) begin errors++; $display("[TB] FAIL rand_error t=%0d got=%b want=%b", t, err, ee); end
    end
  endtask

  initial begin
    $display("[TB] dm_waitstate bench start, bounds check %0d", BOUNDS);
    test_reset();
    test_sweep();
    test_latency();
    test_byte_merge();
    test_illegal();
    test_latched_inputs();
    test_reset_mid_txn();
    test_bounds();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
